fft_channel_scheduler: RTL

Shares the single FFT engine between the two ADC capture channels. When a channel's capture FIFO holds a complete frame, the block grants the FFT to one channel. Arbitration is round-robin or fixed. It issues the FFT start, streams exactly FRAME_LEN samples from the granted FIFO into the FFT input, and waits for FFT completion or a timeout. It sits between the ADC capture FIFOs and the FFT core inside FPGA_control, replacing direct host control of FIFO output enables and FFT enable/select.

---
 rtl/fft_channel_scheduler.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fft_channel_scheduler.sv
// Arbitrates the shared FFT engine between two ADC capture FIFOs and streams
// one FRAME_LEN-sample frame from the granted FIFO per FFT run.
module fft_channel_scheduler #(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned TIMEOUT   = 4095
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              FFT_enable,
  input  logic [1:0]        ch_mask,
  input  logic [1:0]        ch_ready,
  input  logic              mode,
  input  logic              fix_ch,
  input  logic [DATA_W-1:0] fifo_data0,
  input  logic [DATA_W-1:0] fifo_data1,
  output logic [1:0]        fifo_rd_en,
  output logic              fft_start,
  output logic              fft_in_valid,
  output logic [DATA_W-1:0] fft_in_data,
  output logic              fft_in_last,
  input  logic              fft_done,
  output logic              busy,
  output logic              cur_ch,
  output logic [15:0]       frame_cnt,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, WAIT_DONE} state_t;

  state_t             state;
  state_t             next_state;
  logic               last_grant;
  logic [CNT_W-1:0]   rd_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [1:0]         elig;
  logic [1:0]         elig_m;
  logic               grant_any;
  logic               grant_ch;
  logic               rd_last;
  logic               to_hit;
  logic [1:0]         rd_en_d;
  logic               start_d;
  logic               last_d;
  logic               to_err_d;
  logic               done_d;

  // Eligibility and round-robin / fixed-channel choice
  always_comb begin
    elig      = ch_ready & ch_mask & {2{FFT_enable}};
    elig_m    = elig;
    grant_ch  = 1'b0;
    if (mode) elig_m = elig & (fix_ch ? 2'b10 : 2'b01);
    grant_any = |elig_m;
    case (elig_m)
      2'b01:   grant_ch = 1'b0;
      2'b10:   grant_ch = 1'b1;
      2'b11:   grant_ch = ~last_grant;
      default: grant_ch = 1'b0;
    endcase
  end

  assign rd_last = (rd_cnt == CNT_W'(FRAME_LEN - 1));
  assign to_hit  = (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (grant_any) next_state = START;
      START:     next_state = STREAM;
      STREAM:    if (rd_last) next_state = DRAIN;
      DRAIN:     next_state = WAIT_DONE;
      WAIT_DONE: if (fft_done || to_hit) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs; done beats a same-cycle timeout
  always_comb begin
    rd_en_d  = 2'b00;
    start_d  = 1'b0;
    last_d   = 1'b0;
    to_err_d = 1'b0;
    done_d   = 1'b0;
    if (state == IDLE && grant_any) start_d = 1'b1;
    if (next_state == STREAM) rd_en_d = cur_ch ? 2'b10 : 2'b01;
    if (state == STREAM && rd_last) last_d = 1'b1;
    if (state == WAIT_DONE) begin
      done_d   = fft_done;
      to_err_d = ~fft_done & to_hit;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fifo_rd_en   <= 2'b00;
      fft_start    <= 1'b0;
      fft_in_valid <= 1'b0;
      fft_in_last  <= 1'b0;
      busy         <= 1'b0;
      cur_ch       <= 1'b0;
      last_grant   <= 1'b1;
      frame_cnt    <= 16'd0;
      timeout_err  <= 1'b0;
      rd_cnt       <= '0;
      to_cnt       <= '0;
    end else begin
      fifo_rd_en   <= rd_en_d;
      fft_start    <= start_d;
      fft_in_valid <= fifo_rd_en[cur_ch];
      fft_in_last  <= last_d;
      busy         <= (next_state != IDLE);
      timeout_err  <= to_err_d;
      if (start_d) begin
        cur_ch     <= grant_ch;
        last_grant <= grant_ch;
      end
      if (done_d) frame_cnt <= frame_cnt + 16'd1;
      if (state == START)       rd_cnt <= '0;
      else if (state == STREAM) rd_cnt <= rd_cnt + CNT_W'(1);
      if (state == DRAIN)          to_cnt <= '0;
      else if (state == WAIT_DONE) to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // FIFO read data arrives one cycle after the strobe, aligned with fft_in_valid
  assign fft_in_data = fft_in_valid ? (cur_ch ? fifo_data1 : fifo_data0) : '0;

endmodule
